// File: rtl/aes_gcm_pipeline_scheduler.sv
//==============================================================================
// Module   : aes_gcm_pipeline_scheduler
// Brief    : Feeds one AES-GCM job into the first pipeline stage as phase-tagged beats.
// Revision : 1.0
//==============================================================================
`default_nettype none

module aes_gcm_pipeline_scheduler #(
   parameter int PIPE_DEPTH = 12,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [127:0]      job_j0,
   input  logic [CNT_W-1:0]  job_aad_blocks,
   input  logic [CNT_W-1:0]  job_pt_blocks,
   input  logic [63:0]       job_aad_bits,
   input  logic [63:0]       job_pt_bits,
   input  logic              aad_valid,
   output logic              aad_ready,
   input  logic [127:0]      aad_data,
   input  logic              pt_valid,
   output logic              pt_ready,
   input  logic [127:0]      pt_data,
   output logic [2:0]        o_phase,
   output logic [127:0]      o_h,
   output logic [127:0]      o_j0,
   output logic [127:0]      o_cb,
   output logic [127:0]      o_aad,
   output logic [127:0]      o_plain_text,
   output logic [127:0]      o_instance_size,
   output logic              busy,
   output logic              job_done
);

   localparam int c_drain_w = $clog2(PIPE_DEPTH + 1);

   localparam logic [2:0] c_ph_bubble = 3'd0;
   localparam logic [2:0] c_ph_init   = 3'd1;
   localparam logic [2:0] c_ph_aad    = 3'd2;
   localparam logic [2:0] c_ph_pt     = 3'd3;
   localparam logic [2:0] c_ph_len    = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INIT  = 3'd1,
      S_AAD   = 3'd2,
      S_PT    = 3'd3,
      S_LEN   = 3'd4,
      S_DRAIN = 3'd5
   } state_t;

   state_t                 r_state;
   logic [127:0]           r_j0;
   logic [127:0]           r_cb;
   logic [CNT_W-1:0]       r_aad_left;
   logic [CNT_W-1:0]       r_pt_left;
   logic [63:0]            r_aad_bits;
   logic [63:0]            r_pt_bits;
   logic [c_drain_w-1:0]   r_drain;

   state_t                 w_after_aad;
   state_t                 w_after_init;
   logic [127:0]           w_inst;

   // Only the low 32-bit word of the counter block increments; no carry upward.
   function automatic logic [127:0] inc32(input logic [127:0] blk);
      return {blk[127:32], blk[31:0] + 32'd1};
   endfunction

   assign job_ready    = (r_state == S_IDLE);
   assign aad_ready    = (r_state == S_AAD);
   assign pt_ready     = (r_state == S_PT);
   assign busy         = (r_state != S_IDLE);
   assign w_inst       = {r_aad_bits, r_pt_bits};
   assign w_after_aad  = (r_pt_left != '0) ? S_PT : S_LEN;
   assign w_after_init = (r_aad_left != '0) ? S_AAD : w_after_aad;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= S_IDLE;
         r_j0            <= '0;
         r_cb            <= '0;
         r_aad_left      <= '0;
         r_pt_left       <= '0;
         r_aad_bits      <= '0;
         r_pt_bits       <= '0;
         r_drain         <= '0;
         o_phase         <= c_ph_bubble;
         o_h             <= '0;
         o_j0            <= '0;
         o_cb            <= '0;
         o_aad           <= '0;
         o_plain_text    <= '0;
         o_instance_size <= '0;
         job_done        <= 1'b0;
      end else begin
         // Any cycle without a beat presents an all-zero bubble.
         o_phase         <= c_ph_bubble;
         o_h             <= '0;
         o_j0            <= '0;
         o_cb            <= '0;
         o_aad           <= '0;
         o_plain_text    <= '0;
         o_instance_size <= '0;
         job_done        <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (job_valid) begin
                  r_j0       <= job_j0;
                  r_cb       <= inc32(job_j0);
                  r_aad_left <= job_aad_blocks;
                  r_pt_left  <= job_pt_blocks;
                  r_aad_bits <= job_aad_bits;
                  r_pt_bits  <= job_pt_bits;
                  r_state    <= S_INIT;
               end
            end
            S_INIT: begin
               o_phase         <= c_ph_init;
               o_j0            <= r_j0;
               o_cb            <= r_j0;
               o_instance_size <= w_inst;
               r_state         <= w_after_init;
            end
            S_AAD: begin
               if (aad_valid) begin
                  o_phase         <= c_ph_aad;
                  o_j0            <= r_j0;
                  o_cb            <= r_cb;
                  o_aad           <= aad_data;
                  o_instance_size <= w_inst;
                  r_aad_left      <= r_aad_left - CNT_W'(1);
                  if (r_aad_left == CNT_W'(1)) begin
                     r_state <= w_after_aad;
                  end
               end
            end
            S_PT: begin
               if (pt_valid) begin
                  o_phase         <= c_ph_pt;
                  o_j0            <= r_j0;
                  o_cb            <= r_cb;
                  o_plain_text    <= pt_data;
                  o_instance_size <= w_inst;
                  r_cb            <= inc32(r_cb);
                  r_pt_left       <= r_pt_left - CNT_W'(1);
                  if (r_pt_left == CNT_W'(1)) begin
                     r_state <= S_LEN;
                  end
               end
            end
            S_LEN: begin
               o_phase         <= c_ph_len;
               o_j0            <= r_j0;
               o_cb            <= r_cb;
               o_aad           <= w_inst;
               o_instance_size <= w_inst;
               r_drain         <= c_drain_w'(PIPE_DEPTH);
               r_state         <= S_DRAIN;
            end
            S_DRAIN: begin
               // The pulse lands PIPE_DEPTH edges after the LEN beat was loaded.
               if (r_drain == c_drain_w'(1)) begin
                  job_done <= 1'b1;
                  r_drain  <= '0;
                  r_state  <= S_IDLE;
               end else begin
                  r_drain <= r_drain - c_drain_w'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_aes_gcm_pipeline_scheduler.sv
//==============================================================================
// Module   : tb_aes_gcm_pipeline_scheduler
// Brief    : Directed and randomized jobs checked against a beat-sequence model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_aes_gcm_pipeline_scheduler;

   localparam int PIPE_DEPTH = 12;
   localparam int CNT_W      = 16;
   localparam int c_max      = 256;

   typedef struct {
      logic [127:0] j0;
      int           na;
      int           np;
      logic [63:0]  abits;
      logic [63:0]  pbits;
   } job_t;

   logic              clk;
   logic              rst_n;
   logic              job_valid;
   logic              job_ready;
   logic [127:0]      job_j0;
   logic [CNT_W-1:0]  job_aad_blocks;
   logic [CNT_W-1:0]  job_pt_blocks;
   logic [63:0]       job_aad_bits;
   logic [63:0]       job_pt_bits;
   logic              aad_valid;
   logic              aad_ready;
   logic [127:0]      aad_data;
   logic              pt_valid;
   logic              pt_ready;
   logic [127:0]      pt_data;
   logic [2:0]        o_phase;
   logic [127:0]      o_h;
   logic [127:0]      o_j0;
   logic [127:0]      o_cb;
   logic [127:0]      o_aad;
   logic [127:0]      o_plain_text;
   logic [127:0]      o_instance_size;
   logic              busy;
   logic              job_done;

   aes_gcm_pipeline_scheduler #(
      .PIPE_DEPTH (PIPE_DEPTH),
      .CNT_W      (CNT_W)
   ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .job_valid       (job_valid),
      .job_ready       (job_ready),
      .job_j0          (job_j0),
      .job_aad_blocks  (job_aad_blocks),
      .job_pt_blocks   (job_pt_blocks),
      .job_aad_bits    (job_aad_bits),
      .job_pt_bits     (job_pt_bits),
      .aad_valid       (aad_valid),
      .aad_ready       (aad_ready),
      .aad_data        (aad_data),
      .pt_valid        (pt_valid),
      .pt_ready        (pt_ready),
      .pt_data         (pt_data),
      .o_phase         (o_phase),
      .o_h             (o_h),
      .o_j0            (o_j0),
      .o_cb            (o_cb),
      .o_aad           (o_aad),
      .o_plain_text    (o_plain_text),
      .o_instance_size (o_instance_size),
      .busy            (busy),
      .job_done        (job_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   bit           av [c_max];
   bit           pv [c_max];
   logic [127:0] ablk [64];
   logic [127:0] pblk [64];

   // Expected trace, indexed by edges after the accepting edge.
   logic [2:0]   e_ph  [c_max];
   logic [127:0] e_cb  [c_max];
   logic [127:0] e_aad [c_max];
   logic [127:0] e_pt  [c_max];
   bit           e_ar  [c_max];
   bit           e_pr  [c_max];
   int           a_at  [c_max];
   int           p_at  [c_max];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic fill_stim(input bit random_valid);
      for (int i = 0; i < c_max; i++) begin
         av[i] = random_valid && (i < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
         pv[i] = random_valid && (i < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      for (int i = 0; i < 64; i++) begin
         ablk[i] = rnd128();
         pblk[i] = rnd128();
      end
   endtask

   task automatic drive_desc(input job_t j);
      job_j0         = j.j0;
      job_aad_blocks = CNT_W'(j.na);
      job_pt_blocks  = CNT_W'(j.np);
      job_aad_bits   = j.abits;
      job_pt_bits    = j.pbits;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_phase"}, 128'(o_phase), '0);
      chk({tag, "_cb"},    o_cb, '0);
      chk({tag, "_j0"},    o_j0, '0);
      chk({tag, "_aad"},   o_aad, '0);
      chk({tag, "_pt"},    o_plain_text, '0);
      chk({tag, "_inst"},  o_instance_size, '0);
      chk({tag, "_h"},     o_h, '0);
      chk({tag, "_done"},  128'(job_done), '0);
      chk({tag, "_jrdy"},  128'(job_ready), 128'(1));
      chk({tag, "_busy"},  128'(busy), '0);
      chk({tag, "_ardy"},  128'(aad_ready), '0);
      chk({tag, "_prdy"},  128'(pt_ready), '0);
   endtask

   // Runs one job starting at a negedge where the DUT is idle. With hold set, the
   // next descriptor is offered from the LEN cycle onward and left asserted on return.
   task automatic run_job(input string name, input job_t j, input bit rand_jv,
                          input bit hold, input job_t nj, input int abort_k);
      logic [31:0] ctr;
      int c, a, p, len_k, done_k;
      bit beat;
      for (int i = 0; i < c_max; i++) begin
         e_ph[i] = '0; e_cb[i] = '0; e_aad[i] = '0; e_pt[i] = '0;
         e_ar[i] = 1'b0; e_pr[i] = 1'b0; a_at[i] = 0; p_at[i] = 0;
      end
      e_ph[1] = 3'd1;
      e_cb[1] = j.j0;
      ctr = j.j0[31:0] + 32'd1;
      c = 1; a = 0; p = 0;
      while (a < j.na && c < c_max - PIPE_DEPTH - 4) begin
         e_ar[c] = 1'b1; a_at[c] = a;
         if (av[c]) begin
            e_ph[c+1] = 3'd2; e_aad[c+1] = ablk[a]; e_cb[c+1] = {j.j0[127:32], ctr};
            a++;
         end
         c++;
      end
      while (p < j.np && c < c_max - PIPE_DEPTH - 4) begin
         e_pr[c] = 1'b1; p_at[c] = p;
         if (pv[c]) begin
            e_ph[c+1] = 3'd3; e_pt[c+1] = pblk[p]; e_cb[c+1] = {j.j0[127:32], ctr};
            ctr = ctr + 32'd1;
            p++;
         end
         c++;
      end
      len_k  = c + 1;
      e_ph[len_k]  = 3'd4;
      e_aad[len_k] = {j.abits, j.pbits};
      e_cb[len_k]  = {j.j0[127:32], ctr};
      done_k = len_k + PIPE_DEPTH;

      drive_desc(j);
      job_valid = 1'b1;
      chk({name, "_accept_ready"}, 128'(job_ready), 128'(1));
      for (int k = 0; k <= done_k; k++) begin
         @(negedge clk);
         beat = (e_ph[k] != 3'd0);
         chk($sformatf("%s_phase@%0d", name, k), 128'(o_phase), 128'(e_ph[k]));
         chk($sformatf("%s_cb@%0d", name, k),    o_cb, e_cb[k]);
         chk($sformatf("%s_aad@%0d", name, k),   o_aad, e_aad[k]);
         chk($sformatf("%s_pt@%0d", name, k),    o_plain_text, e_pt[k]);
         chk($sformatf("%s_j0@%0d", name, k),    o_j0, beat ? j.j0 : '0);
         chk($sformatf("%s_inst@%0d", name, k),  o_instance_size, beat ? {j.abits, j.pbits} : '0);
         chk($sformatf("%s_h@%0d", name, k),     o_h, '0);
         chk($sformatf("%s_done@%0d", name, k),  128'(job_done), 128'(k == done_k));
         chk($sformatf("%s_jrdy@%0d", name, k),  128'(job_ready), 128'(k == done_k));
         chk($sformatf("%s_busy@%0d", name, k),  128'(busy), 128'(k != done_k));
         chk($sformatf("%s_ardy@%0d", name, k),  128'(aad_ready), 128'(e_ar[k]));
         chk($sformatf("%s_prdy@%0d", name, k),  128'(pt_ready), 128'(e_pr[k]));
         if (k == abort_k) begin
            #2 rst_n = 1'b0;
            #1 chk_all_zero({name, "_inreset"});
            aad_valid = 1'b0; pt_valid = 1'b0; job_valid = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            for (int q = 0; q < PIPE_DEPTH + 8; q++) begin
               @(negedge clk);
               chk_all_zero($sformatf("%s_postreset@%0d", name, q));
            end
            return;
         end
         aad_valid = av[k];
         aad_data  = e_ar[k] ? ablk[a_at[k]] : rnd128();
         pt_valid  = pv[k];
         pt_data   = e_pr[k] ? pblk[p_at[k]] : rnd128();
         if (hold && k >= len_k) begin
            drive_desc(nj);
            job_valid = 1'b1;
         end else begin
            job_valid = (rand_jv && k < done_k) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
      if (!hold) begin
         aad_valid = 1'b0;
         pt_valid  = 1'b0;
      end
   endtask

   initial begin
      job_t j, nj;
      rst_n = 1'b0; job_valid = 1'b0; job_j0 = '0; job_aad_blocks = '0; job_pt_blocks = '0;
      job_aad_bits = '0; job_pt_bits = '0; aad_valid = 1'b0; aad_data = '0;
      pt_valid = 1'b0; pt_data = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_all_zero("idle");

      // 1 AAD + 2 PT, streams always valid; early stream data must be ignored.
      fill_stim(1'b0);
      j = '{j0: {rnd128() >> 32, 32'h0000_0001}, na: 1, np: 2, abits: 64'd128, pbits: 64'd256};
      run_job("basic", j, 1'b0, 1'b0, j, -1);
      @(negedge clk);

      fill_stim(1'b0);
      j = '{j0: rnd128(), na: 0, np: 0, abits: 64'd0, pbits: 64'd0};
      run_job("empty", j, 1'b0, 1'b0, j, -1);
      @(negedge clk);

      fill_stim(1'b0);
      j = '{j0: {rnd128() >> 32, 32'hFFFF_FFFE}, na: 0, np: 3, abits: 64'd0, pbits: 64'd384};
      run_job("wrap", j, 1'b0, 1'b0, j, -1);
      @(negedge clk);

      // pt_valid 1,0,0,1 over the PT stage cycles.
      fill_stim(1'b0);
      for (int i = 0; i < c_max; i++) pv[i] = 1'b0;
      pv[1] = 1'b1; pv[4] = 1'b1;
      j = '{j0: rnd128(), na: 0, np: 2, abits: 64'd0, pbits: 64'd200};
      run_job("toggle", j, 1'b0, 1'b0, j, -1);
      @(negedge clk);

      // Reset lands during the PT stage (cycles 2..5 for this shape).
      fill_stim(1'b0);
      j = '{j0: rnd128(), na: 1, np: 4, abits: 64'd100, pbits: 64'd500};
      run_job("abort", j, 1'b0, 1'b0, j, 3);
      fill_stim(1'b1);
      j = '{j0: rnd128(), na: 2, np: 3, abits: 64'd256, pbits: 64'd300};
      run_job("after_abort", j, 1'b0, 1'b0, j, -1);
      @(negedge clk);

      // Next descriptor held through DRAIN; accepted only after job_done.
      fill_stim(1'b0);
      j  = '{j0: rnd128(), na: 1, np: 1, abits: 64'd128, pbits: 64'd128};
      nj = '{j0: rnd128(), na: 2, np: 1, abits: 64'd250, pbits: 64'd7};
      run_job("drain_hold", j, 1'b0, 1'b1, nj, -1);
      fill_stim(1'b0);
      run_job("drain_next", nj, 1'b0, 1'b0, nj, -1);
      @(negedge clk);

      for (int r = 0; r < 6; r++) begin
         fill_stim(1'b1);
         j.j0    = rnd128();
         if (r[0]) j.j0[31:0] = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
         j.na    = $urandom_range(0, 5);
         j.np    = $urandom_range(0, 5);
         j.abits = {$urandom, $urandom};
         j.pbits = {$urandom, $urandom};
         run_job($sformatf("rand%0d", r), j, 1'b1, 1'b0, j, -1);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/aes_gcm_pipeline_scheduler.md
Name: aes_gcm_pipeline_scheduler

Overview:
- Sequences one AES-GCM job at a time into the first stage of the AES-GCM encryption pipeline.
- Accepts a job descriptor: J0, AAD/PT block counts and bit lengths.
- Issues one phase-tagged beat per cycle: INIT (H and J0), AAD blocks, PT blocks with incrementing counter block, LEN block.
- Drains the pipeline and pulses job_done when the last beat exits.

Parameters:
- PIPE_DEPTH, 12, cycles from beat issue to exit of the last pipeline stage (>=1).
- CNT_W, 16, width of the block counters job_aad_blocks and job_pt_blocks.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- job_valid  in  1  descriptor valid
- job_ready  out  1  descriptor accepted when job_valid&job_ready at clk edge
- job_j0  in  128  pre-counter block J0
- job_aad_blocks  in  CNT_W  number of 128-bit AAD blocks (0 allowed)
- job_pt_blocks  in  CNT_W  number of 128-bit PT blocks (0 allowed)
- job_aad_bits  in  64  len(A) in bits
- job_pt_bits  in  64  len(P) in bits
- aad_valid / aad_ready / aad_data  in/out/in  1/1/128  AAD block stream, zero-padded upstream
- pt_valid / pt_ready / pt_data  in/out/in  1/1/128  PT block stream, zero-padded upstream
- o_phase  out  3  beat type: 0 bubble, 1 INIT, 2 AAD, 3 PT, 4 LEN
- o_h  out  128  H-derivation input (all zero on INIT)
- o_j0  out  128  J0 of the current job
- o_cb  out  128  counter block
- o_aad  out  128  AAD block, or length block on LEN
- o_plain_text  out  128  PT block
- o_instance_size  out  128  {job_aad_bits, job_pt_bits}, constant for the job
- busy  out  1  high in any state other than IDLE
- job_done  out  1  one-cycle pulse

Behaviour:
- Reset values: all o_* and job_done are 0; state IDLE; job_ready=1.
- Reset is asynchronous and may assert mid-job: the job is abandoned with no job_done pulse; the next beat is a bubble.
- All o_* are registered. Every cycle with no beat loads o_phase=0 and all data outputs 0.
- FSM states: IDLE, INIT, AAD, PT, LEN, DRAIN.
- IDLE:
  - job_ready=1.
  - On handshake, latch the descriptor.
  - cb <= inc32(J0), where inc32 adds 1 to bits [96:127] mod 2^32 and leaves bits [0:95] unchanged.
  - Go to INIT.
- INIT:
  - On the next edge load o_phase=1, o_h=0, o_j0=J0, o_cb=J0, o_instance_size.
  - Go to AAD if aad_blocks>0, else PT if pt_blocks>0, else LEN.
- AAD:
  - aad_ready=1 (combinational from state).
  - On handshake load o_phase=2, o_aad=aad_data, o_cb=cb, and decrement the remaining count.
  - After the last block go to PT if pt_blocks>0, else LEN.
  - Without aad_valid, issue a bubble.
- PT:
  - pt_ready=1.
  - On handshake load o_phase=3, o_plain_text=pt_data, o_cb=cb, and set cb <= inc32(cb).
  - After the last block go to LEN. Without pt_valid, issue a bubble.
  - Counter wrap 0xFFFFFFFF -> 0x00000000 in the low word is legal and must not carry into bits [0:95].
- LEN:
  - Load o_phase=4, o_aad={aad_bits, pt_bits}, o_cb=cb.
  - Go to DRAIN and load the drain counter with PIPE_DEPTH.
- DRAIN:
  - Decrement the counter each cycle, issuing bubbles.
  - At zero, pulse job_done for 1 cycle and go to IDLE.
- In every beat, o_j0 and o_instance_size carry the latched job values.
- aad_ready and pt_ready are 0 outside their own states. Stream data presented early is ignored until its state.
- Latency:
  - Handshake edge e0 -> INIT beat visible after edge e0+1.
  - LEN loaded at edge eL -> job_done high during the cycle after edge eL+PIPE_DEPTH.
- A new job is accepted only in IDLE. Back-to-back jobs have at least one IDLE cycle between them.
- job_valid held during IDLE with zero counts is legal: the sequence is INIT, LEN, DRAIN.

Test Plan:
- Job: J0=0x..._00000001, aad_blocks=1, pt_blocks=2, streams always valid -> phases 1,2,3,3,4 on consecutive cycles.
  - PT o_cb = ..._00000002 then ..._00000003.
  - job_done exactly PIPE_DEPTH cycles after the LEN beat.
- Zero-length job (0 AAD, 0 PT, bits 0) -> phases 1,4; LEN o_aad=0; job_done pulses; no aad_ready/pt_ready assertion.
- J0 low word 0xFFFFFFFE, pt_blocks=3 -> o_cb low words 0xFFFFFFFF, 0x00000000, 0x00000001; upper 96 bits unchanged.
- pt_valid toggled 1,0,0,1 with pt_blocks=2 -> beats 3,0,0,3. Counter advances only on handshakes.
- rst_n asserted during PT mid-job -> outputs 0 immediately; no job_done; job_ready=1 after release; a new job runs correctly.
- job_valid asserted during DRAIN -> job_ready=0, no accept; accepted on the first IDLE cycle after job_done.
